// File: rtl/lut_ram_lsu_pkg.sv
// lut_ram_lsu_pkg: access size and FSM state types shared by the lut_ram load/store unit.
package lut_ram_lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        RESP
    } lsu_state_t;

    function automatic logic [2:0] size_bytes(input mem_size_t s);
        return s == SIZE_B ? 3'd1 : s == SIZE_H ? 3'd2 : s == SIZE_W ? 3'd4 : 3'd0;
    endfunction

endpackage

// File: rtl/lut_ram_lsu_lane_align.sv
// lsu_lane_align: byte-lane store merge and load extract/extend over a two-word window.
module lsu_lane_align
    import lut_ram_lsu_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  mem_size_t   size,
    input  logic        hi,
    input  logic        uns,
    input  logic [31:0] ld_lo,
    input  logic [31:0] ld_hi,
    output logic [31:0] st_word,
    output logic [31:0] ld_data
);

    logic [63:0] st_data;
    logic [7:0]  st_mask;
    logic [31:0] data_h;
    logic [3:0]  lanes;
    logic [31:0] ld_raw;

    // Store data and lane mask are laid over the word pair; hi selects the upper word.
    always_comb begin
        st_data = {32'b0, wdata} << {off, 3'b000};
        st_mask = {4'b0, size == SIZE_B ? 4'b0001 : size == SIZE_H ? 4'b0011 : 4'b1111} << off;
        data_h  = hi ? st_data[63:32] : st_data[31:0];
        lanes   = hi ? st_mask[7:4] : st_mask[3:0];
        for (int i = 0; i < 4; i++)
            st_word[8*i +: 8] = lanes[i] ? data_h[8*i +: 8] : old_word[8*i +: 8];
        ld_raw  = 32'({ld_hi, ld_lo} >> {off, 3'b000});
        ld_data = size == SIZE_B ? {{24{~uns & ld_raw[7]}}, ld_raw[7:0]} :
                  size == SIZE_H ? {{16{~uns & ld_raw[15]}}, ld_raw[15:0]} : ld_raw;
    end

endmodule

// File: rtl/lut_ram_lsu.sv
// lut_ram_lsu: byte/half/word load-store front-end for lut_ram; stores are read-modify-write.
// Define LUT_RAM_LSU_MISALIGNED_EN to split word-spanning accesses over ACC0/ACC1.
module lut_ram_lsu
    import lut_ram_lsu_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int XLEN      = 32,
    localparam int ADDR_W   = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [XLEN-1:0]   mem_wr_data,
    input  logic [XLEN-1:0]   mem_rd_data
);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d, uns_q, uns_d, err_q, err_d;
    mem_size_t         size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [XLEN-1:0]   wdata_q, wdata_d, lo_q, lo_d, rdata_q, rdata_d;
    logic [XLEN-1:0]   ld_data;
    logic [ADDR_W-1:0] req_word;
    logic [1:0]        req_off;
    logic [2:0]        req_end;
    logic              req_span, req_err;

    always_comb begin
        req_word = req_addr[ADDR_W+1:2];
        req_off  = req_addr[1:0];
        req_end  = {1'b0, req_off} + size_bytes(mem_size_t'(req_size));
        req_span = req_end > 3'd4;
        req_err  = (req_addr >> (ADDR_W + 2)) != '0 ||
                   int'(req_word) + int'(req_span) >= MEM_DEPTH ||
                   req_size == SIZE_X;
`ifndef LUT_RAM_LSU_MISALIGNED_EN
        req_err  = req_err | req_span;
`endif
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        lo_d        = lo_q;
        rdata_d     = rdata_q;
        mem_wr_en   = 1'b0;
        mem_rd_addr = state_q == ACC1 ? word_q + 1'b1 : word_q;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d    = req_we;
                size_d  = mem_size_t'(req_size);
                uns_d   = req_unsigned;
                off_d   = req_off;
                word_d  = req_word;
                wdata_d = req_wdata;
                err_d   = req_err;
                lo_d    = '0;
                rdata_d = '0;
                state_d = req_err ? RESP : ACC0;
            end
            ACC0: begin
                mem_wr_en = we_q;
                lo_d      = mem_rd_data;
                rdata_d   = we_q ? '0 : ld_data;
`ifdef LUT_RAM_LSU_MISALIGNED_EN
                state_d   = ({1'b0, off_q} + size_bytes(size_q)) > 3'd4 ? ACC1 : RESP;
`else
                state_d   = RESP;
`endif
            end
`ifdef LUT_RAM_LSU_MISALIGNED_EN
            ACC1: begin
                mem_wr_en = we_q;
                rdata_d   = we_q ? '0 : ld_data;
                state_d   = RESP;
            end
`endif
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    assign mem_wr_addr = mem_rd_addr;
    assign req_ready   = state_q == IDLE;
    assign rsp_valid   = state_q == RESP;
    assign rsp_err     = rsp_valid & err_q;
    assign rsp_rdata   = rsp_valid ? rdata_q : '0;

    // In ACC1 the low word came from ACC0 and was parked in lo_q.
    lsu_lane_align u_align (
        .old_word (mem_rd_data),
        .wdata    (wdata_q),
        .off      (off_q),
        .size     (size_q),
        .hi       (state_q == ACC1),
        .uns      (uns_q),
        .ld_lo    (state_q == ACC1 ? lo_q : mem_rd_data),
        .ld_hi    (mem_rd_data),
        .st_word  (mem_wr_data),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SIZE_B;
            uns_q   <= 1'b0;
            off_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_lut_ram_lsu.sv
// tb_lut_ram_lsu: randomized load/store traffic against a byte-array reference memory.
module tb_lut_ram_lsu;

    localparam int D  = 1024;
    localparam int AW = $clog2(D);
`ifdef LUT_RAM_LSU_MISALIGNED_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic [31:0]   req_addr = '0, req_wdata = '0;
    logic          req_ready, rsp_valid, rsp_err, mem_wr_en;
    logic [31:0]   rsp_rdata, mem_wr_data, mem_rd_data;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;

    logic [31:0] ram [D];
    logic [7:0]  refm [4*D];
    logic        allow_wr = 1'b0;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    lut_ram_lsu #(.MEM_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always @(posedge clk) if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
    assign mem_rd_data = ram[mem_rd_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_wr_en", 32'(mem_wr_en), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
        end else begin
            chk("addr_tie", 32'(mem_wr_addr), 32'(mem_rd_addr));
            if (mem_wr_en) chk("wr_allowed", 32'(allow_wr), 1);
        end
    end

    function automatic int nbytes(input logic [1:0] sz);
        return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : sz == 2'd2 ? 4 : 0;
    endfunction

    // Expected error, load data and accept-to-valid latency from the byte-level memory.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                         output logic err, output logic [31:0] rd, output int lat);
        int nb;
        longint last;
        logic span;
        logic [31:0] v;
        nb   = nbytes(sz);
        last = longint'({32'b0, a}) + nb - 1;
        span = int'(a[1:0]) + nb > 4;
        err  = sz == 2'd3 || last >= 4 * D || (!MIS && span);
        lat  = err ? 1 : span ? 3 : 2;
        v = '0;
        if (!err && !we)
            for (int i = 0; i < nb; i++) v |= 32'(refm[int'(a) + i]) << (8 * i);
        rd = (err || we) ? 32'd0 :
             sz == 2'd0 ? (uns ? {24'b0, v[7:0]} : {{24{v[7]}}, v[7:0]}) :
             sz == 2'd1 ? (uns ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]}) : v;
    endtask

    task automatic run(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] got_rd, output logic got_err);
        logic e;
        logic [31:0] r;
        int lat, n;
        model(we, sz, uns, a, e, r, lat);
        got_rd  = 'x;
        got_err = 1'bx;
        chk("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        allow_wr = we && !e;
        @(posedge clk); #1;
        req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom_range(0, 127); req_wdata = $urandom;
        n = 1;
        while (!rsp_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, lat);
        allow_wr = 1'b0;
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_rdata", rsp_rdata, r);
            chk("hold_err", 32'(rsp_err), 32'(e));
            chk("hold_req_ready", 32'(req_ready), 0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_rdata", rsp_rdata, r);
        chk("rsp_err", 32'(rsp_err), 32'(e));
        chk("busy_req_ready", 32'(req_ready), 0);
        got_rd  = rsp_rdata;
        got_err = rsp_err;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("done_valid", 32'(rsp_valid), 0);
        chk("done_req_ready", 32'(req_ready), 1);
        if (we && !e)
            for (int i = 0; i < nbytes(sz); i++) refm[int'(a) + i] = wd[8*i +: 8];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, w10, w14, a, wd;
        logic        er, we;
        logic [1:0]  sz;
        for (int i = 0; i < 4 * D; i++) refm[i] = 8'h00;
        #12;
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_err", 32'(rsp_err), 0);
        chk("reset_req_ready", 32'(req_ready), 1);
        chk("reset_wr_en", 32'(mem_wr_en), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int w = 0; w < 32; w++) run(1'b1, 2'd2, 1'b0, 32'(4 * w), $urandom, 0, rd, er);
        for (int w = D - 8; w < D; w++) run(1'b1, 2'd2, 1'b0, 32'(4 * w), $urandom, 0, rd, er);

        run(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, er);
        run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er);
        chk("lw_10", rd, 32'hDEADBEEF);
        chk("lw_10_err", 32'(er), 0);
        run(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000A5, 0, rd, er);
        run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er);
        chk("sb_merge", rd, 32'hDEADA5EF);
        run(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0, rd, er);
        chk("lb_sign", rd, 32'hFFFFFFA5);
        run(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0, rd, er);
        chk("lbu_zero", rd, 32'h000000A5);

        run(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, er);
        run(1'b1, 2'd2, 1'b0, 32'h14, 32'h01234567, 0, rd, er);
        run(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 0, rd, er);
        chk("lw_span_data", rd, MIS ? 32'h4567DEAD : 32'h0);
        chk("lw_span_err", 32'(er), MIS ? 0 : 1);
        run(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0, rd, er);
        chk("lw_14", rd, 32'h01234567);

        run(1'b1, 2'd2, 1'b0, 32'(4 * D), 32'h12345678, 0, rd, er);
        chk("sw_oor_err", 32'(er), 1);
        run(1'b1, 2'd1, 1'b0, 32'(4 * (D - 1) + 3), 32'h0000BEEF, 0, rd, er);
        chk("sh_last_span_err", 32'(er), 1);
        run(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0, rd, er);
        chk("bad_size_err", 32'(er), 1);
        run(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 5, rd, er);
        chk("lh_hold", rd, 32'hFFFFDEAD);

        // Reset lands in ACC1 (split build) or RESP (default build) of a spanning store.
        w10 = ram[4];
        w14 = ram[5];
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h13; req_wdata = 32'h11223344;
        allow_wr = MIS;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (MIS) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        allow_wr = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 0);
        chk("abort_word10", ram[4], MIS ? {8'h44, w10[23:0]} : w10);
        chk("abort_word14", ram[5], w14);
        if (MIS) refm[32'h13] = 8'h44;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_valid", 32'(rsp_valid), 0);
            chk("post_rst_ready", 32'(req_ready), 1);
        end

        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 9))
                0, 1:    a = $urandom_range(4 * D - 32, 4 * D + 3);
                2:       a = $urandom;
                default: a = $urandom_range(0, 127);
            endcase
            sz = 2'($urandom);
            if (sz == 2'd3 && $urandom_range(0, 3) != 0) sz = 2'd2;
            we = 1'($urandom);
            wd = $urandom;
            run(we, sz, 1'($urandom), a, wd, $urandom_range(0, 2), rd, er);
        end

        for (int w = 0; w < D; w++)
            if (w < 32 || w >= D - 8)
                chk($sformatf("mem_word_%0d", w), ram[w],
                    {refm[4*w+3], refm[4*w+2], refm[4*w+1], refm[4*w]});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
